// File: rtl/onewire_pkg.sv
// 1-Wire transmitter shared types and constants.
// Default slot timing, ROM command bytes, FSM state encodings.
package onewire_pkg;

  localparam int DEF_T_SLOT = 60;
  localparam int DEF_T_LOW0 = 60;
  localparam int DEF_T_LOW1 = 6;
  localparam int DEF_T_REC  = 11;

  localparam logic [7:0] READ_ROM   = 8'h33;
  localparam logic [7:0] MATCH_ROM  = 8'h55;
  localparam logic [7:0] SKIP_ROM   = 8'hCC;
  localparam logic [7:0] SEARCH_ROM = 8'hF0;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOW,
    TX_HIGH,
    TX_REC,
    TX_FIN
  } tx_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_FIN
  } seq_state_t;

endpackage

// File: rtl/onewire_write_slot.sv
// One 1-Wire write slot: low phase, released phase, recovery.
// Back-to-back slots chain without gaps when go arrives on slot_done.
module onewire_write_slot
  import onewire_pkg::*;
#(
  parameter int T_SLOT = DEF_T_SLOT,
  parameter int T_LOW0 = DEF_T_LOW0,
  parameter int T_LOW1 = DEF_T_LOW1,
  parameter int T_REC  = DEF_T_REC,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_val,
  input  logic kill,
  output logic bus_oe,
  output logic slot_done
);

  localparam int HIGH0 = T_SLOT - T_LOW0;
  localparam int HIGH1 = T_SLOT - T_LOW1;

  localparam logic [CNT_W-1:0] LOW0_M1  = CNT_W'(T_LOW0 - 1);
  localparam logic [CNT_W-1:0] LOW1_M1  = CNT_W'(T_LOW1 - 1);
  localparam logic [CNT_W-1:0] HIGH0_M1 =
    CNT_W'((HIGH0 > 0) ? HIGH0 - 1 : 0);
  localparam logic [CNT_W-1:0] HIGH1_M1 = CNT_W'(HIGH1 - 1);
  localparam logic [CNT_W-1:0] REC_M1   = CNT_W'(T_REC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             bit_q;

  // last recovery cycle: the sequencer may chain the next bit here
  assign slot_done = (state == TX_REC) && (cnt == '0);

  // slot phase sequencing; counter holds remaining phase cycles - 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      bit_q  <= 1'b0;
      bus_oe <= 1'b0;
    end else if (kill) begin
      state  <= TX_IDLE;
      cnt    <= '0;
      bus_oe <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (go) begin
            state  <= TX_LOW;
            bus_oe <= 1'b1;
            bit_q  <= bit_val;
            cnt    <= bit_val ? LOW1_M1 : LOW0_M1;
          end
        end
        TX_LOW: begin
          if (cnt == '0) begin
            bus_oe <= 1'b0;
            if (!bit_q && (HIGH0 == 0)) begin
              state <= TX_REC;
              cnt   <= REC_M1;
            end else begin
              state <= TX_HIGH;
              cnt   <= bit_q ? HIGH1_M1 : HIGH0_M1;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        TX_HIGH: begin
          if (cnt == '0) begin
            state <= TX_REC;
            cnt   <= REC_M1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        TX_REC: begin
          if (cnt == '0) begin
            if (go) begin
              state  <= TX_LOW;
              bus_oe <= 1'b1;
              bit_q  <= bit_val;
              cnt    <= bit_val ? LOW1_M1 : LOW0_M1;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state  <= TX_IDLE;
          bus_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/onewire_cmd_tx.sv
// 1-Wire byte-sequence transmitter, LSB-first, open-drain enable.
// Sequences bits/bytes and the start/done/abort handshake.
module onewire_cmd_tx
  import onewire_pkg::*;
#(
  parameter int MAX_BYTES = 9,
  parameter int T_SLOT    = DEF_T_SLOT,
  parameter int T_LOW0    = DEF_T_LOW0,
  parameter int T_LOW1    = DEF_T_LOW1,
  parameter int T_REC     = DEF_T_REC,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0]             num_bytes,
  input  logic [8*MAX_BYTES-1:0] data_in,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   bus_oe
);

  localparam int BW = $clog2(MAX_BYTES + 1);

  seq_state_t             state;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [BW-1:0]          nbytes_q;
  logic [BW-1:0]          byte_idx;
  logic [2:0]             bit_idx;

  logic [BW-1:0] n_clamp;
  logic          launch;
  logic          last_bit;
  logic          advance;
  logic          slot_go;
  logic          slot_bit;
  logic          slot_done;

  // launch/chain decisions; data_q[0] is always the next bit to send
  always_comb begin
    n_clamp  = (int'(num_bytes) > MAX_BYTES) ?
               BW'(MAX_BYTES) : BW'(num_bytes);
    launch   = (state == SEQ_IDLE) && start && !abort &&
               (num_bytes != '0);
    last_bit = (bit_idx == 3'd7) &&
               (byte_idx == nbytes_q - BW'(1));
    advance  = (state == SEQ_RUN) && slot_done &&
               !abort && !last_bit;
    slot_go  = launch || advance;
    slot_bit = launch ? data_in[0] : data_q[0];
  end

  onewire_write_slot #(
    .T_SLOT (T_SLOT),
    .T_LOW0 (T_LOW0),
    .T_LOW1 (T_LOW1),
    .T_REC  (T_REC),
    .CNT_W  (CNT_W)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (slot_go),
    .bit_val   (slot_bit),
    .kill      (abort),
    .bus_oe    (bus_oe),
    .slot_done (slot_done)
  );

  // transfer sequencer: latch request, walk bits, report completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEQ_IDLE;
      data_q   <= '0;
      nbytes_q <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (start && !abort) begin
            if (num_bytes == '0) begin
              done <= 1'b1;
            end else begin
              state    <= SEQ_RUN;
              busy     <= 1'b1;
              data_q   <= data_in >> 1;
              nbytes_q <= n_clamp;
              byte_idx <= '0;
              bit_idx  <= '0;
            end
          end
        end
        SEQ_RUN: begin
          if (abort) begin
            state <= SEQ_IDLE;
            busy  <= 1'b0;
          end else if (slot_done) begin
            if (last_bit) begin
              state <= SEQ_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              data_q  <= data_q >> 1;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                byte_idx <= byte_idx + BW'(1);
              end
            end
          end
        end
        SEQ_FIN: begin
          state <= SEQ_IDLE;
        end
        default: begin
          state <= SEQ_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_cmd_tx.sv
// Directed bench for onewire_cmd_tx: decodes bus pulses LSB-first
// and checks slot timing, done timing, abort, ignore and reset.
module tb_onewire_cmd_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  num_bytes;
  logic [71:0] data_in;
  logic        abort;
  logic        busy;
  logic        done;
  logic        bus_oe;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int p_start[$];
  int p_len[$];
  int d_cyc[$];
  int busy_cnt = 0;
  int ps = 0;
  logic prev_oe = 1'b0;

  typedef struct {
    logic [3:0]  nb;
    logic [71:0] dat;
    int          exp_n;
  } vec_t;

  vec_t vt[5];

  onewire_cmd_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_bytes (num_bytes),
    .data_in   (data_in),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .bus_oe    (bus_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_oe && !prev_oe) ps = cyc;
    if (!bus_oe && prev_oe) begin
      p_start.push_back(ps);
      p_len.push_back(cyc - ps);
    end
    if (done) d_cyc.push_back(cyc);
    if (busy) busy_cnt = busy_cnt + 1;
    prev_oe = bus_oe;
  end

  task automatic check(input string nm,
                       input logic [71:0] act,
                       input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input string nm, input logic [3:0] nb,
                          input logic [71:0] dat, input int exp_n,
                          input int ig1, input int ig2);
    int pb, db, bc0, t0, lim, np, nd, terr, s, l;
    logic [71:0] dec, expd;
    pb  = p_start.size();
    db  = d_cyc.size();
    bc0 = busy_cnt;
    for (int i = 0; i < 72; i++)
      expd[i] = (i < 8 * exp_n) ? dat[i] : 1'b0;
    start     = 1'b1;
    num_bytes = nb;
    data_in   = dat;
    t0        = cyc + 1;
    @(posedge clk); #1;
    start     = 1'b0;
    num_bytes = 4'd2;
    data_in   = {9{8'hFF}};
    lim = 568 * exp_n + 40;
    for (int i = 0; i < lim; i++) begin
      start = ((ig1 > 0 && cyc == t0 + ig1) ||
               (ig2 > 0 && cyc == t0 + ig2));
      @(posedge clk); #1;
    end
    start = 1'b0;
    np = p_start.size() - pb;
    check({nm, " pulses"}, 72'(np), 72'(8 * exp_n));
    terr = 0;
    dec  = '0;
    for (int i = 0; i < np && i < 72; i++) begin
      s = p_start[pb + i];
      l = p_len[pb + i];
      dec[i] = (l < 33);
      if (s != t0 + 71 * i) terr++;
      if (l != (expd[i] ? 6 : 60)) terr++;
    end
    check({nm, " slot timing errs"}, 72'(terr), 72'(0));
    check({nm, " decoded"}, dec, expd);
    nd = d_cyc.size() - db;
    check({nm, " done count"}, 72'(nd), 72'(1));
    check({nm, " done cycle"},
          72'((nd > 0) ? d_cyc[db] - t0 : -1), 72'(568 * exp_n));
    check({nm, " busy cycles"}, 72'(busy_cnt - bc0), 72'(568 * exp_n));
    check({nm, " idle oe"}, 72'(bus_oe), 72'(0));
  endtask

  initial begin
    int pb, db, bc0, t0;
    vt[0] = '{4'd1, 72'h55, 1};
    vt[1] = '{4'd9, {64'h2801_2345_6789_ABCD, 8'h55}, 9};
    vt[2] = '{4'd0, 72'h55, 0};
    vt[3] = '{4'd15, 72'hA5_0F_F0_33_CC_55_AA_01_80, 9};
    vt[4] = '{4'd2, 72'h3C_F0, 2};

    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    num_bytes = 4'd0;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 72'(busy), 72'(0));
    check("reset done", 72'(done), 72'(0));
    check("reset oe", 72'(bus_oe), 72'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++)
      run_xfer($sformatf("vec%0d", v), vt[v].nb, vt[v].dat,
               vt[v].exp_n, 0, 0);

    run_xfer("ignore", 4'd1, 72'h55, 1, 10, 300);

    // abort during LOW of bit 3
    pb  = p_start.size();
    db  = d_cyc.size();
    start     = 1'b1;
    num_bytes = 4'd1;
    data_in   = 72'h00;
    t0        = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 218) begin
      @(posedge clk); #1;
    end
    check("abort pre oe", 72'(bus_oe), 72'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort oe", 72'(bus_oe), 72'(0));
    check("abort busy", 72'(busy), 72'(0));
    repeat (700) @(posedge clk);
    #1;
    check("abort no done", 72'(d_cyc.size() - db), 72'(0));
    check("abort pulses", 72'(p_start.size() - pb), 72'(4));

    // abort and start together while idle
    pb  = p_start.size();
    db  = d_cyc.size();
    bc0 = busy_cnt;
    start     = 1'b1;
    abort     = 1'b1;
    num_bytes = 4'd1;
    data_in   = 72'h55;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("abort+start busy", 72'(busy_cnt - bc0), 72'(0));
    check("abort+start pulses", 72'(p_start.size() - pb), 72'(0));
    check("abort+start done", 72'(d_cyc.size() - db), 72'(0));

    run_xfer("restart", 4'd1, 72'hA5, 1, 0, 0);

    // asynchronous reset mid-slot
    db = d_cyc.size();
    start     = 1'b1;
    num_bytes = 4'd1;
    data_in   = 72'h00;
    t0        = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 20) begin
      @(posedge clk); #1;
    end
    check("pre-reset oe", 72'(bus_oe), 72'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset oe", 72'(bus_oe), 72'(0));
    check("async reset busy", 72'(busy), 72'(0));
    check("async reset done", 72'(done), 72'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    check("reset no done", 72'(d_cyc.size() - db), 72'(0));

    run_xfer("skip_rom", 4'd1, 72'hCC, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
